// File: rtl/xif_offload_pkg.sv
// Shared types for the CORE-V-XIF offload tracker: scoreboard states,
// error causes and the buffered result record.
package xif_offload_pkg;

  // Result records carry a fixed-width ID; narrower tracker IDs are zero-extended.
  localparam int unsigned XIF_ID_W_MAX = 8;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    ISSUED    = 2'd1,
    COMMITTED = 2'd2
  } sb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE              = 2'd0,
    ERR_UNEXPECTED_RESULT = 2'd1,
    ERR_SPURIOUS_COMMIT   = 2'd2,
    ERR_ID_REUSE          = 2'd3
  } err_cause_e;

  typedef struct packed {
    logic [XIF_ID_W_MAX-1:0] id;
    logic [4:0]              rd;
    logic [31:0]             data;
    logic                    we;
  } x_result_entry_t;

  // Highest-priority cause among the errors seen in one cycle.
  function automatic err_cause_e pick_cause(input logic unexp, input logic spur, input logic reuse);
    if (unexp)      return ERR_UNEXPECTED_RESULT;
    else if (spur)  return ERR_SPURIOUS_COMMIT;
    else if (reuse) return ERR_ID_REUSE;
    else            return ERR_NONE;
  endfunction

endpackage

// File: rtl/xif_result_fifo.sv
// Small result FIFO; the head is read straight from the storage registers, so a
// push becomes visible on valid_o no earlier than the following cycle.
module xif_result_fifo #(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = logic [31:0]
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t push_data_i,
  output logic   full_o,
  output logic   valid_o,
  input  logic   ready_i,
  output entry_t data_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [NW-1:0]   count_reg;
  logic            pop;
  logic            push;

  assign full_o  = (count_reg == NW'(DEPTH));
  assign valid_o = (count_reg != '0);
  assign data_o  = mem[rd_ptr_reg];
  assign push    = push_i & ~full_o;
  assign pop     = valid_o & ready_i;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + NW'(1);
      else if (pop && !push) count_reg <= count_reg - NW'(1);
    end
  end

endmodule

// File: rtl/xif_offload_tracker.sv
// Tracks offloaded XIF instructions from issue through commit to result,
// throttles outstanding IDs, narrows operand ports and buffers results.
module xif_offload_tracker
  import xif_offload_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH        = 4,
  parameter int unsigned CORE_NUM_RS       = 3,
  parameter int unsigned CPROC_NUM_RS      = 2,
  parameter int unsigned MAX_OUTSTANDING   = 4,
  parameter int unsigned RESULT_FIFO_DEPTH = 2,
  localparam int unsigned CW               = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      core_issue_valid_i,
  output logic                      core_issue_ready_o,
  input  logic [31:0]               core_issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]     core_issue_id_i,
  input  logic [CORE_NUM_RS*32-1:0] core_issue_rs_i,
  input  logic [CORE_NUM_RS-1:0]    core_issue_rs_valid_i,
  output logic                      core_issue_accept_o,
  output logic                      core_issue_writeback_o,
  output logic                      cp_issue_valid_o,
  input  logic                      cp_issue_ready_i,
  output logic [31:0]               cp_issue_instr_o,
  output logic [X_ID_WIDTH-1:0]     cp_issue_id_o,
  output logic [CPROC_NUM_RS*32-1:0] cp_issue_rs_o,
  output logic [CPROC_NUM_RS-1:0]   cp_issue_rs_valid_o,
  input  logic                      cp_issue_accept_i,
  input  logic                      cp_issue_writeback_i,
  input  logic                      commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]     commit_id_i,
  input  logic                      commit_kill_i,
  input  logic                      cp_result_valid_i,
  output logic                      cp_result_ready_o,
  input  logic [X_ID_WIDTH-1:0]     cp_result_id_i,
  input  logic [4:0]                cp_result_rd_i,
  input  logic [31:0]               cp_result_data_i,
  input  logic                      cp_result_we_i,
  output logic                      core_result_valid_o,
  input  logic                      core_result_ready_i,
  output logic [X_ID_WIDTH-1:0]     core_result_id_o,
  output logic [4:0]                core_result_rd_o,
  output logic [31:0]               core_result_data_o,
  output logic                      core_result_we_o,
  output logic [CW-1:0]             outstanding_o,
  output logic                      err_o,
  output logic [1:0]                err_cause_o
);

  localparam int unsigned NUM_ID = 2 ** X_ID_WIDTH;

  if (!((CPROC_NUM_RS == 2) || (CPROC_NUM_RS == 3)) || (CPROC_NUM_RS > CORE_NUM_RS)) begin : g_bad_rs
    $error("CPROC_NUM_RS must be 2 or 3 and not exceed CORE_NUM_RS");
  end
  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > NUM_ID)) begin : g_bad_max
    $error("MAX_OUTSTANDING must be in 1..2**X_ID_WIDTH");
  end
  if ((RESULT_FIFO_DEPTH < 1) || (X_ID_WIDTH > XIF_ID_W_MAX)) begin : g_bad_fifo
    $error("RESULT_FIFO_DEPTH must be >= 1 and X_ID_WIDTH <= XIF_ID_W_MAX");
  end

  sb_state_e       state_reg  [NUM_ID];
  sb_state_e       state_next [NUM_ID];
  logic            wb_reg     [NUM_ID];
  logic            wb_next    [NUM_ID];
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic            err_reg;
  err_cause_e      err_cause_reg;
  logic            reuse_prev_reg;
  logic [X_ID_WIDTH-1:0] reuse_id_reg;

  logic block, fire, alloc;
  logic reuse_cond, reuse_evt;
  logic spurious_commit, unexpected_result;
  logic push_en, push_ok, fifo_full;
  x_result_entry_t push_entry, head_entry;
  logic unused_bits;

  // Issue path: purely combinational gating of the handshake.
  assign block = (outstanding_reg == CW'(MAX_OUTSTANDING)) || (state_reg[core_issue_id_i] != FREE);
  assign cp_issue_valid_o       = core_issue_valid_i & ~block;
  assign core_issue_ready_o     = cp_issue_ready_i & ~block;
  assign cp_issue_instr_o       = core_issue_instr_i;
  assign cp_issue_id_o          = core_issue_id_i;
  assign cp_issue_rs_o          = core_issue_rs_i[CPROC_NUM_RS*32-1:0];
  assign cp_issue_rs_valid_o    = core_issue_rs_valid_i[CPROC_NUM_RS-1:0];
  assign core_issue_accept_o    = cp_issue_accept_i;
  assign core_issue_writeback_o = cp_issue_writeback_i;

  assign fire  = core_issue_valid_i & core_issue_ready_o;
  assign alloc = fire & cp_issue_accept_i;

  // A commit racing an allocation of the same ID targets the new entry.
  assign spurious_commit = commit_valid_i && (state_reg[commit_id_i] == FREE) &&
                           !(alloc && (core_issue_id_i == commit_id_i));

  assign cp_result_ready_o = ~fifo_full;
  assign push_en           = cp_result_valid_i & cp_result_ready_o;
  assign push_ok           = push_en && (state_reg[cp_result_id_i] == COMMITTED) && wb_reg[cp_result_id_i];
  assign unexpected_result = push_en & ~push_ok;

  // ID_REUSE fires only on the first cycle of each stalled attempt.
  assign reuse_cond = core_issue_valid_i && (state_reg[core_issue_id_i] != FREE);
  assign reuse_evt  = reuse_cond && !(reuse_prev_reg && (reuse_id_reg == core_issue_id_i));

  for (genvar gi = 0; gi < NUM_ID; gi++) begin : g_entry
    always_comb begin
      state_next[gi] = state_reg[gi];
      wb_next[gi]    = wb_reg[gi];
      if (alloc && (core_issue_id_i == X_ID_WIDTH'(gi))) begin
        state_next[gi] = ISSUED;
        wb_next[gi]    = cp_issue_writeback_i;
      end
      if (commit_valid_i && (commit_id_i == X_ID_WIDTH'(gi)) && (state_next[gi] != FREE)) begin
        state_next[gi] = (commit_kill_i || !wb_next[gi]) ? FREE : COMMITTED;
      end
      if (push_ok && (cp_result_id_i == X_ID_WIDTH'(gi))) begin
        state_next[gi] = FREE;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg[gi] <= FREE;
        wb_reg[gi]    <= 1'b0;
      end else begin
        state_reg[gi] <= state_next[gi];
        wb_reg[gi]    <= wb_next[gi];
      end
    end
  end

  // Count derived from the next scoreboard so it always matches non-FREE entries.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_ID; i++) begin
      if (state_next[i] != FREE) cnt++;
    end
    outstanding_next = CW'(cnt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
      err_cause_reg   <= ERR_NONE;
      reuse_prev_reg  <= 1'b0;
      reuse_id_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      reuse_prev_reg  <= reuse_cond;
      reuse_id_reg    <= core_issue_id_i;
      if (!err_reg && (unexpected_result || spurious_commit || reuse_evt)) begin
        err_reg       <= 1'b1;
        err_cause_reg <= pick_cause(unexpected_result, spurious_commit, reuse_evt);
      end
    end
  end

  assign push_entry = '{id:   XIF_ID_W_MAX'(cp_result_id_i),
                        rd:   cp_result_rd_i,
                        data: cp_result_data_i,
                        we:   cp_result_we_i};

  xif_result_fifo #(
    .DEPTH   (RESULT_FIFO_DEPTH),
    .entry_t (x_result_entry_t)
  ) u_result_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_ok),
    .push_data_i (push_entry),
    .full_o      (fifo_full),
    .valid_o     (core_result_valid_o),
    .ready_i     (core_result_ready_i),
    .data_o      (head_entry)
  );

  assign core_result_id_o   = head_entry.id[X_ID_WIDTH-1:0];
  assign core_result_rd_o   = head_entry.rd;
  assign core_result_data_o = head_entry.data;
  assign core_result_we_o   = head_entry.we;
  assign outstanding_o      = outstanding_reg;
  assign err_o              = err_reg;
  assign err_cause_o        = err_cause_reg;

  assign unused_bits = ^{head_entry.id, core_issue_rs_i, core_issue_rs_valid_i};

endmodule

// File: tb/tb_xif_offload_tracker.sv
// Directed bench for xif_offload_tracker with a result scoreboard queue.
module tb_xif_offload_tracker;

  localparam int XW = 4;
  localparam int CW = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            core_issue_valid_i = 1'b0;
  logic            core_issue_ready_o;
  logic [31:0]     core_issue_instr_i = '0;
  logic [XW-1:0]   core_issue_id_i = '0;
  logic [95:0]     core_issue_rs_i = '0;
  logic [2:0]      core_issue_rs_valid_i = '0;
  logic            core_issue_accept_o;
  logic            core_issue_writeback_o;
  logic            cp_issue_valid_o;
  logic            cp_issue_ready_i = 1'b1;
  logic [31:0]     cp_issue_instr_o;
  logic [XW-1:0]   cp_issue_id_o;
  logic [63:0]     cp_issue_rs_o;
  logic [1:0]      cp_issue_rs_valid_o;
  logic            cp_issue_accept_i = 1'b1;
  logic            cp_issue_writeback_i = 1'b1;
  logic            commit_valid_i = 1'b0;
  logic [XW-1:0]   commit_id_i = '0;
  logic            commit_kill_i = 1'b0;
  logic            cp_result_valid_i = 1'b0;
  logic            cp_result_ready_o;
  logic [XW-1:0]   cp_result_id_i = '0;
  logic [4:0]      cp_result_rd_i = '0;
  logic [31:0]     cp_result_data_i = '0;
  logic            cp_result_we_i = 1'b0;
  logic            core_result_valid_o;
  logic            core_result_ready_i = 1'b0;
  logic [XW-1:0]   core_result_id_o;
  logic [4:0]      core_result_rd_o;
  logic [31:0]     core_result_data_o;
  logic            core_result_we_o;
  logic [CW-1:0]   outstanding_o;
  logic            err_o;
  logic [1:0]      err_cause_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [41:0] exp_q [$];

  xif_offload_tracker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_issue_valid_i(core_issue_valid_i), .core_issue_ready_o(core_issue_ready_o),
    .core_issue_instr_i(core_issue_instr_i), .core_issue_id_i(core_issue_id_i),
    .core_issue_rs_i(core_issue_rs_i), .core_issue_rs_valid_i(core_issue_rs_valid_i),
    .core_issue_accept_o(core_issue_accept_o), .core_issue_writeback_o(core_issue_writeback_o),
    .cp_issue_valid_o(cp_issue_valid_o), .cp_issue_ready_i(cp_issue_ready_i),
    .cp_issue_instr_o(cp_issue_instr_o), .cp_issue_id_o(cp_issue_id_o),
    .cp_issue_rs_o(cp_issue_rs_o), .cp_issue_rs_valid_o(cp_issue_rs_valid_o),
    .cp_issue_accept_i(cp_issue_accept_i), .cp_issue_writeback_i(cp_issue_writeback_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .cp_result_valid_i(cp_result_valid_i), .cp_result_ready_o(cp_result_ready_o),
    .cp_result_id_i(cp_result_id_i), .cp_result_rd_i(cp_result_rd_i),
    .cp_result_data_i(cp_result_data_i), .cp_result_we_i(cp_result_we_i),
    .core_result_valid_o(core_result_valid_o), .core_result_ready_i(core_result_ready_i),
    .core_result_id_o(core_result_id_o), .core_result_rd_o(core_result_rd_o),
    .core_result_data_o(core_result_data_o), .core_result_we_o(core_result_we_o),
    .outstanding_o(outstanding_o), .err_o(err_o), .err_cause_o(err_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // Each accepted pop is compared against the oldest expected result.
  always @(negedge clk_i) begin
    if (rst_ni && core_result_valid_o && core_result_ready_i) begin
      if (exp_q.size() == 0) begin
        check("result_unexpected_pop", 64'(core_result_data_o), 64'hFFFF_FFFF_FFFF);
      end else begin
        logic [41:0] e;
        e = exp_q.pop_front();
        check("result_record", 64'({core_result_id_o, core_result_rd_o, core_result_data_o, core_result_we_o}), 64'(e));
        $display("result pop: id=%0d rd=%0d data=%08h we=%0d", core_result_id_o, core_result_rd_o, core_result_data_o, core_result_we_o);
      end
    end
  end

  task automatic issue(input int id, input logic acc, input logic wb);
    core_issue_valid_i = 1'b1; core_issue_id_i = XW'(id);
    cp_issue_accept_i = acc; cp_issue_writeback_i = wb;
    tick();
    core_issue_valid_i = 1'b0;
    $display("issue: id=%0d accept=%0d wb=%0d outstanding=%0d", id, acc, wb, outstanding_o);
  endtask

  task automatic commit(input int id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = XW'(id); commit_kill_i = kill;
    tick();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    $display("commit: id=%0d kill=%0d outstanding=%0d", id, kill, outstanding_o);
  endtask

  // Drive a result, waiting (bounded) for ready; expectation queued only if it should be buffered.
  task automatic result(input int id, input logic [31:0] data, input logic expect_buffered);
    int waited;
    cp_result_valid_i = 1'b1; cp_result_id_i = XW'(id);
    cp_result_rd_i = 5'(id + 1); cp_result_data_i = data; cp_result_we_i = 1'b1;
    waited = 0;
    #1;
    while (!cp_result_ready_o && waited < 20) begin tick(); waited++; end
    if (!cp_result_ready_o) check("result_ready_timeout", 64'(cp_result_ready_o), 64'd1);
    if (expect_buffered) exp_q.push_back({XW'(id), 5'(id + 1), data, 1'b1});
    tick();
    cp_result_valid_i = 1'b0;
    $display("result push: id=%0d data=%08h outstanding=%0d", id, data, outstanding_o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("reset_outstanding", 64'(outstanding_o), 64'd0);
    check("reset_result_valid", 64'(core_result_valid_o), 64'd0);
    check("reset_err", 64'({err_o, err_cause_o}), 64'd0);
    check("reset_result_ready", 64'(cp_result_ready_o), 64'd1);

    // Basic flow on ID 3 with operand narrowing.
    core_issue_rs_i = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    core_issue_rs_valid_i = 3'b111;
    core_issue_instr_i = 32'h1234_5678;
    core_issue_valid_i = 1'b1; core_issue_id_i = 4'd3;
    #1;
    check("issue_valid_pass", 64'({cp_issue_valid_o, core_issue_ready_o}), 64'b11);
    check("issue_rs_valid_trunc", 64'(cp_issue_rs_valid_o), 64'b11);
    check("issue_rs_trunc", cp_issue_rs_o, 64'hBBBB_BBBB_AAAA_AAAA);
    check("issue_instr_id", 64'({cp_issue_instr_o, cp_issue_id_o}), {28'd0, 32'h1234_5678, 4'd3});
    issue(3, 1'b1, 1'b1);
    check("t1_outstanding_issue", 64'(outstanding_o), 64'd1);
    commit(3, 1'b0);
    check("t1_outstanding_commit", 64'(outstanding_o), 64'd1);
    core_result_ready_i = 1'b1;
    cp_result_valid_i = 1'b1; cp_result_id_i = 4'd3; cp_result_rd_i = 5'd4;
    cp_result_data_i = 32'hDEAD_BEEF; cp_result_we_i = 1'b1;
    #1;
    check("t1_valid_before_push", 64'(core_result_valid_o), 64'd0);
    exp_q.push_back({4'd3, 5'd4, 32'hDEAD_BEEF, 1'b1});
    tick();
    cp_result_valid_i = 1'b0;
    check("t1_valid_after_push", 64'(core_result_valid_o), 64'd1);
    check("t1_data", 64'(core_result_data_o), 64'hDEAD_BEEF);
    check("t1_outstanding_result", 64'(outstanding_o), 64'd0);
    tick();
    check("t1_fifo_drained", 64'(core_result_valid_o), 64'd0);

    // Outstanding limit.
    for (int i = 0; i < 4; i++) issue(i, 1'b1, 1'b0);
    check("t2_outstanding_full", 64'(outstanding_o), 64'd4);
    core_issue_valid_i = 1'b1; core_issue_id_i = 4'd4;
    #1;
    check("t2_blocked", 64'({cp_issue_valid_o, core_issue_ready_o}), 64'b00);
    commit_valid_i = 1'b1; commit_id_i = 4'd0;
    tick();
    commit_valid_i = 1'b0;
    check("t2_unblocked", 64'({cp_issue_valid_o, core_issue_ready_o}), 64'b11);
    check("t2_outstanding_after_free", 64'(outstanding_o), 64'd3);
    tick();
    core_issue_valid_i = 1'b0;
    check("t2_id4_issued", 64'(outstanding_o), 64'd4);
    for (int i = 1; i < 5; i++) commit(i, 1'b0);
    check("t2_outstanding_clear", 64'(outstanding_o), 64'd0);

    // Same-cycle issue and kill of ID 5.
    commit_valid_i = 1'b1; commit_id_i = 4'd5; commit_kill_i = 1'b1;
    issue(5, 1'b1, 1'b1);
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    check("t3_outstanding", 64'(outstanding_o), 64'd0);
    check("t3_no_err", 64'(err_o), 64'd0);

    // Unexpected result, then a spurious commit that must not override the cause.
    result(7, 32'h7777_7777, 1'b0);
    check("t4_err_cause", 64'({err_o, err_cause_o}), 64'b101);
    check("t4_no_result", 64'(core_result_valid_o), 64'd0);
    commit(9, 1'b0);
    check("t4_cause_held", 64'({err_o, err_cause_o}), 64'b101);

    // FIFO backpressure and ordering.
    core_result_ready_i = 1'b0;
    for (int i = 8; i < 11; i++) issue(i, 1'b1, 1'b1);
    for (int i = 8; i < 11; i++) commit(i, 1'b0);
    result(8, 32'h100, 1'b1);
    result(9, 32'h101, 1'b1);
    cp_result_valid_i = 1'b1; cp_result_id_i = 4'd10;
    #1;
    check("t5_ready_full", 64'(cp_result_ready_o), 64'd0);
    cp_result_valid_i = 1'b0;
    check("t5_outstanding", 64'(outstanding_o), 64'd1);
    core_result_ready_i = 1'b1;
    result(10, 32'h102, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("t5_drained", 64'(exp_q.size()), 64'd0);
    check("t5_outstanding_zero", 64'(outstanding_o), 64'd0);

    // Asynchronous reset with in-flight state.
    core_result_ready_i = 1'b0;
    issue(2, 1'b1, 1'b1);
    commit(2, 1'b0);
    result(2, 32'h222, 1'b1);
    issue(6, 1'b1, 1'b1);
    check("t6_pre_reset", 64'({core_result_valid_o, outstanding_o}), {60'd0, 1'b1, 3'd1});
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check("t6_reset_outstanding", 64'(outstanding_o), 64'd0);
    check("t6_reset_fifo", 64'(core_result_valid_o), 64'd0);
    check("t6_reset_err", 64'({err_o, err_cause_o}), 64'd0);
    tick();
    rst_ni = 1'b1;

    // ID reuse, then spurious commit after a fresh reset.
    issue(1, 1'b1, 1'b1);
    core_issue_valid_i = 1'b1; core_issue_id_i = 4'd1;
    #1;
    check("t7_reuse_blocked", 64'({cp_issue_valid_o, core_issue_ready_o}), 64'b00);
    tick();
    core_issue_valid_i = 1'b0;
    check("t7_reuse_cause", 64'({err_o, err_cause_o}), 64'b111);
    do_reset();
    commit(12, 1'b0);
    check("t8_spurious_cause", 64'({err_o, err_cause_o}), 64'b110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
